addsub_seq: RTL and testbench

Parametrised, multi-cycle integer add/subtract unit for the RISC-V calculator datapath. It replaces the single-cycle combinational 32-bit adder where area matters. Each cycle it processes one CHUNK-bit slice, from the LSB upward, using a registered carry. The start/busy/done handshake and the status flags (carry, signed overflow, zero) let the controller sequence it without knowing its latency.

---
 rtl/addsub_seq.sv | 110 +++++++++++
 tb/tb_addsub_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle add/subtract unit.
// One CHUNK-bit slice per cycle, LSB first, through a registered carry.
module addsub_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] aluout,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [IW-1:0]    idx;
  logic             last;
  logic             accept;
  logic [CHUNK-1:0] sa;
  logic [CHUNK-1:0] sb;
  logic [CHUNK-1:0] ss;
  logic             sc;
  logic             cmsb;

  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign last   = (idx == IW'(N - 1));
  assign accept = start && (state != RUN);

  // slice adder plus merged result and carry into the MSB
  always_comb begin
    sa   = opa[idx*CHUNK +: CHUNK];
    sb   = opb[idx*CHUNK +: CHUNK];
    {sc, ss} = {1'b0, sa} + {1'b0, sb}
             + {{CHUNK{1'b0}}, carry};
    res  = acc;
    res[idx*CHUNK +: CHUNK] = ss;
    cmsb = ss[CHUNK-1] ^ sa[CHUNK-1] ^ sb[CHUNK-1];
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (last)  state_nxt = DONE;
      DONE: state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // operand capture, slice accumulation and result/flag update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa      <= '0;
      opb      <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      aluout   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (accept) begin
      opa   <= srca;
      opb   <= sub ? ~srcb : srcb;
      carry <= sub;
      acc   <= '0;
      idx   <= '0;
    end else if (state == RUN) begin
      acc   <= res;
      carry <= sc;
      idx   <= idx + IW'(1);
      if (last) begin
        aluout   <= res;
        cout     <= sc;
        overflow <= cmsb ^ sc;
        zero     <= (res == '0);
      end
    end
  end

endmodule

// File: tb/tb_addsub_seq.sv
// tb_addsub_seq: scoreboard bench for addsub_seq.
// Three instances: CHUNK = 8, 32 and 1.
module tb_addsub_seq;

  typedef struct {
    logic [31:0] r;
    logic        c;
    logic        v;
    logic        z;
    int          at;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] start;
  logic [2:0] sub_i;
  logic [2:0] busy;
  logic [2:0] done;
  logic [2:0] cout;
  logic [2:0] ovf;
  logic [2:0] zero;
  logic [2:0][31:0] a_i;
  logic [2:0][31:0] b_i;
  logic [2:0][31:0] aluout;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[3][$];
  exp_t last[3];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : gd
    addsub_seq #(
      .WIDTH(32),
      .CHUNK(g == 0 ? 8 : (g == 1 ? 32 : 1))
    ) u (
      .clk(clk),
      .rst_n(rst_n),
      .start(start[g]),
      .sub(sub_i[g]),
      .srca(a_i[g]),
      .srcb(b_i[g]),
      .busy(busy[g]),
      .done(done[g]),
      .aluout(aluout[g]),
      .cout(cout[g]),
      .overflow(ovf[g]),
      .zero(zero[g])
    );
  end

  function automatic int nn(int g);
    return g == 0 ? 4 : (g == 1 ? 1 : 32);
  endfunction

  // reference: plain integer arithmetic
  function automatic exp_t model(bit s, logic [31:0] a,
                                 logic [31:0] b);
    exp_t e;
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    longint sr;
    sr   = s ? sa - sb : sa + sb;
    e.r  = s ? a - b : a + b;
    e.c  = s ? (ua >= ub) : ((ua + ub) > 64'hffff_ffff);
    e.v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    e.z  = (e.r == 32'd0);
    e.at = 0;
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hffff_ffff;
      2: return 32'h7fff_ffff;
      3: return 32'h8000_0000;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(string nm, int g, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d got %h want %h",
               nm, g, cyc, act, exp);
    end
  endtask

  task automatic chk1(string nm, int g, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d got %b want %b",
               nm, g, cyc, act, exp);
    end
  endtask

  // monitor: compare every cycle against scoreboard
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      bit ed;
      bit eb;
      if (!rst_n) begin
        q[g].delete();
        last[g] = '{default: 0};
      end
      ed = q[g].size() > 0 && q[g][0].at == cyc;
      eb = q[g].size() > 0 && q[g][0].at > cyc
        && (q[g][0].at - nn(g)) <= cyc;
      chk1("done", g, done[g], ed);
      chk1("busy", g, busy[g], eb);
      if (ed) last[g] = q[g].pop_front();
      chk("aluout", g, aluout[g], last[g].r);
      chk1("cout", g, cout[g], last[g].c);
      chk1("overflow", g, ovf[g], last[g].v);
      chk1("zero", g, zero[g], last[g].z);
    end
  end

  task automatic issue(int g, bit s, logic [31:0] a,
                       logic [31:0] b);
    exp_t e;
    @(negedge clk);
    if (q[g].size() == 0 || q[g][q[g].size()-1].at <= cyc) begin
      e    = model(s, a, b);
      e.at = cyc + 1 + nn(g);
      q[g].push_back(e);
    end
    start[g] = 1'b1;
    sub_i[g] = s;
    a_i[g]   = a;
    b_i[g]   = b;
    @(posedge clk);
    #1;
    start[g] = 1'b0;
    sub_i[g] = 1'($urandom_range(0, 1));
    a_i[g]   = $urandom;
    b_i[g]   = $urandom;
  endtask

  task automatic drain(int g);
    for (int i = 0; i < 100; i++) begin
      if (q[g].size() == 0) break;
      @(negedge clk);
    end
    checks++;
    if (q[g].size() != 0) begin
      errors++;
      $display("FAIL timeout dut%0d pending %0d", g, q[g].size());
      q[g].delete();
    end
  endtask

  task automatic chk_zero(string nm);
    for (int g = 0; g < 3; g++) begin
      chk({nm, "_aluout"}, g, aluout[g], 32'd0);
      chk1({nm, "_busy"}, g, busy[g], 1'b0);
      chk1({nm, "_done"}, g, done[g], 1'b0);
      chk1({nm, "_flags"}, g, |{cout[g], ovf[g], zero[g]}, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = '0;
    sub_i = '0;
    a_i   = '0;
    b_i   = '0;
    repeat (3) @(negedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    for (int g = 0; g < 3; g++) begin
      issue(g, 0, 32'h0000_0eff, 32'h0000_0234);
      drain(g);
      issue(g, 1, 32'h0000_0005, 32'h0000_0005);
      drain(g);
      issue(g, 1, 32'h0000_0000, 32'h0000_0001);
      drain(g);
      issue(g, 0, 32'h7fff_ffff, 32'h0000_0001);
      drain(g);
      issue(g, 0, 32'hffff_ffff, 32'h0000_0001);
      drain(g);
      issue(g, 0, 32'h1234_5678, 32'h1111_1111);
      @(negedge clk);
      issue(g, 1, 32'hdead_beef, 32'h0000_0001);
      drain(g);
      issue(g, 1, 32'h8000_0000, 32'h0000_0001);
      repeat (nn(g)) @(negedge clk);
      issue(g, 0, 32'h0f0f_0f0f, 32'hf0f0_f0f1);
      drain(g);
    end

    issue(0, 0, 32'h1357_9bdf, 32'h2468_ace0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 1, 32'h0000_1000, 32'h0000_0fff);
    drain(0);

    repeat (300) begin
      int g;
      g = $urandom_range(0, 2);
      issue(g, 1'($urandom_range(0, 1)), pick(), pick());
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    for (int g = 0; g < 3; g++) drain(g);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
